// File: rtl/circle_param_if.sv
// circle_param_if: keypad/vsync inputs and committed circle parameters
// between the keypad front end and the VGA circle renderer.
interface circle_param_if;
  logic       key_ready;
  logic [4:0] key_code;
  logic       vs;
  logic [9:0] x;
  logic [8:0] y;
  logic [9:0] radius;
  logic [19:0] r_sqr;
  logic       upd;

  modport master (
    output key_ready, key_code, vs,
    input  x, y, radius, r_sqr, upd
  );

  modport slave (
    input  key_ready, key_code, vs,
    output x, y, radius, r_sqr, upd
  );
endinterface

// File: rtl/circle_param_ctrl.sv
// circle_param_ctrl: keypad-driven circle centre/radius with auto-repeat,
// iterative radius^2 and frame-aligned commit to the renderer.
module circle_param_ctrl #(
  parameter int unsigned X_MAX   = 639,
  parameter int unsigned Y_MAX   = 479,
  parameter int unsigned R_MIN   = 5,
  parameter int unsigned R_MAX   = 200,
  parameter int unsigned STEP_XY = 20,
  parameter int unsigned STEP_R  = 5,
  parameter int unsigned X_INIT  = 320,
  parameter int unsigned Y_INIT  = 240,
  parameter int unsigned R_INIT  = 15,
  parameter int unsigned REP_DLY = 1 << 24,
  parameter int unsigned REP_PER = 1 << 22
) (
  input  logic          clk,
  input  logic          rstn,
  circle_param_if.slave io
);

  localparam logic [9:0] XI = 10'(X_INIT);
  localparam logic [8:0] YI = 9'(Y_INIT);
  localparam logic [9:0] RI = 10'(R_INIT);
  localparam logic [19:0] SQI = 20'(R_INIT * R_INIT);
  localparam logic [31:0] REP_RLD = 32'(REP_DLY - REP_PER + 1);

  typedef enum logic {
    M_IDLE,
    M_RUN
  } mst_t;

  logic        k1, k2, k3;
  logic        key_rise;
  logic        rep_hit;
  logic [31:0] rep_cnt;
  logic [4:0]  code_q;
  logic        cmd;
  logic [4:0]  cmd_code;

  logic        d_rdn, d_rup;
  logic        d_xdn, d_xup;
  logic        d_ydn, d_yup;

  logic [9:0]  sh_x, x_nx;
  logic [8:0]  sh_y, y_nx;
  logic [9:0]  sh_r, r_nx;
  logic [19:0] sh_sq;
  logic        r_chg;

  mst_t        m_st, m_nx;
  logic [19:0] mcand;
  logic [9:0]  mplier;
  logic [19:0] acc, acc_nx;
  logic [3:0]  mcnt;
  logic        busy, done;

  logic        vs_q;
  logic        fs;
  logic        pend;
  logic        commit;

  // key_ready is asynchronous: k1/k2 synchronise, k3 gives the edge
  always_ff @(posedge clk) begin
    if (!rstn) begin
      k1 <= 1'b0;
      k2 <= 1'b0;
      k3 <= 1'b0;
    end else begin
      k1 <= io.key_ready;
      k2 <= k1;
      k3 <= k2;
    end
  end

  assign key_rise = k2 & ~k3;
  assign rep_hit  = k2 & k3 & (rep_cnt == REP_DLY);

  // rep_cnt counts cycles since the edge; after the first repeat it is
  // reloaded so the next hit lands REP_PER cycles later
  always_ff @(posedge clk) begin
    if (!rstn || !k2) begin
      rep_cnt <= '0;
    end else if (rep_hit) begin
      rep_cnt <= REP_RLD;
    end else begin
      rep_cnt <= rep_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      code_q <= '0;
    end else if (key_rise) begin
      code_q <= io.key_code;
    end
  end

  assign cmd      = key_rise | rep_hit;
  assign cmd_code = key_rise ? io.key_code : code_q;

  assign d_rdn = cmd & (cmd_code == 5'h10);
  assign d_rup = cmd & (cmd_code == 5'h12);
  assign d_xdn = cmd & (cmd_code == 5'h0C);
  assign d_xup = cmd & (cmd_code == 5'h0E);
  assign d_ydn = cmd & (cmd_code == 5'h09);
  assign d_yup = cmd & (cmd_code == 5'h11);

  always_comb begin
    x_nx = sh_x;
    y_nx = sh_y;
    r_nx = sh_r;
    unique case (1'b1)
      d_xdn: x_nx = (sh_x < 10'(STEP_XY)) ? 10'd0
                  : sh_x - 10'(STEP_XY);
      d_xup: x_nx = (sh_x > 10'(X_MAX - STEP_XY)) ? 10'(X_MAX)
                  : sh_x + 10'(STEP_XY);
      d_ydn: y_nx = (sh_y < 9'(STEP_XY)) ? 9'd0
                  : sh_y - 9'(STEP_XY);
      d_yup: y_nx = (sh_y > 9'(Y_MAX - STEP_XY)) ? 9'(Y_MAX)
                  : sh_y + 9'(STEP_XY);
      d_rdn: r_nx = (sh_r < 10'(R_MIN + STEP_R)) ? 10'(R_MIN)
                  : sh_r - 10'(STEP_R);
      d_rup: r_nx = (sh_r > 10'(R_MAX - STEP_R)) ? 10'(R_MAX)
                  : sh_r + 10'(STEP_R);
      default: ;
    endcase
  end

  assign r_chg = (r_nx != sh_r);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sh_x <= XI;
      sh_y <= YI;
      sh_r <= RI;
    end else begin
      sh_x <= x_nx;
      sh_y <= y_nx;
      sh_r <= r_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      m_st <= M_IDLE;
    end else begin
      m_st <= m_nx;
    end
  end

  always_comb begin
    m_nx = m_st;
    unique case (m_st)
      M_IDLE: if (r_chg) m_nx = M_RUN;
      M_RUN: begin
        if (r_chg) begin
          m_nx = M_RUN;
        end else if (mcnt == 4'd9) begin
          m_nx = M_IDLE;
        end
      end
    endcase
  end

  assign busy   = (m_st == M_RUN);
  assign done   = busy & (mcnt == 4'd9);
  assign acc_nx = acc + (mplier[0] ? mcand : 20'd0);

  // a radius change always wins over the running product
  always_ff @(posedge clk) begin
    if (!rstn) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      mcnt   <= '0;
      sh_sq  <= SQI;
    end else if (r_chg) begin
      mcand  <= {10'd0, r_nx};
      mplier <= r_nx;
      acc    <= '0;
      mcnt   <= '0;
    end else if (busy) begin
      acc    <= acc_nx;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      mcnt   <= mcnt + 4'd1;
      if (done) begin
        sh_sq <= acc_nx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      vs_q <= 1'b1;
    end else begin
      vs_q <= io.vs;
    end
  end

  assign fs     = vs_q & ~io.vs;
  assign commit = (fs & (~busy | done)) | (pend & done);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pend <= 1'b0;
    end else if (commit) begin
      pend <= 1'b0;
    end else if (fs & busy) begin
      pend <= 1'b1;
    end
  end

  // the commit copies the shadow as it was before any same-cycle command
  always_ff @(posedge clk) begin
    if (!rstn) begin
      io.x      <= XI;
      io.y      <= YI;
      io.radius <= RI;
      io.r_sqr  <= SQI;
      io.upd    <= 1'b0;
    end else begin
      io.upd <= commit;
      if (commit) begin
        io.x      <= sh_x;
        io.y      <= sh_y;
        io.radius <= sh_r;
        io.r_sqr  <= busy ? acc_nx : sh_sq;
      end
    end
  end

endmodule

// File: tb/tb_circle_param_ctrl.sv
// tb_circle_param_ctrl: directed and random keypad/vsync stimulus checked
// every cycle against a frame-level behavioural model.
module tb_circle_param_ctrl;
  localparam int RD = 100;
  localparam int RP = 20;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  circle_param_if bus ();

  circle_param_ctrl #(
    .REP_DLY(RD),
    .REP_PER(RP)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .io  (bus.slave)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  int m_x = 320, m_y = 240, m_r = 15, m_sq = 225;
  bit m_upd = 1'b0;
  int sh_x, sh_y, sh_r;
  int s1, s2, s3, vs_prev;
  int t, code, lastchg, cyc_n;
  bit pend;

  function automatic int sat(int v, int lo, int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  // model: a key edge or repeat time is one command; radius^2 is ready
  // 10 cycles after the last radius change; vsync fall commits the frame
  initial begin
    bit lvl, cmd, fs, busy, done, commit;
    int old_r;
    cyc_n = 0;
    forever begin
      @(posedge clk);
      cyc_n++;
      if (!rstn) begin
        sh_x = 320; sh_y = 240; sh_r = 15;
        m_x = 320; m_y = 240; m_r = 15; m_sq = 225;
        m_upd = 0; s1 = 0; s2 = 0; s3 = 0;
        vs_prev = 1; t = 0; code = 0;
        lastchg = -100; pend = 0;
      end else begin
        lvl = (s2 != 0);
        cmd = 0;
        if (lvl && s3 == 0) begin
          t = 0;
          code = int'(bus.key_code);
          cmd = 1;
        end else if (lvl) begin
          t++;
          cmd = (t >= RD) && ((t - RD) % RP == 0);
        end
        fs = (vs_prev != 0) && !bus.vs;
        busy = (cyc_n > lastchg) && (cyc_n <= lastchg + 10);
        done = (cyc_n == lastchg + 10);
        commit = (fs && (!busy || done)) || (pend && done);
        m_upd = commit;
        if (commit) begin
          m_x = sh_x; m_y = sh_y;
          m_r = sh_r; m_sq = sh_r * sh_r;
          pend = 0;
        end else if (fs && busy) begin
          pend = 1;
        end
        old_r = sh_r;
        if (cmd) begin
          case (code)
            'h10: sh_r = sat(sh_r - 5, 5, 200);
            'h12: sh_r = sat(sh_r + 5, 5, 200);
            'h0C: sh_x = sat(sh_x - 20, 0, 639);
            'h0E: sh_x = sat(sh_x + 20, 0, 639);
            'h09: sh_y = sat(sh_y - 20, 0, 479);
            'h11: sh_y = sat(sh_y + 20, 0, 479);
            default: ;
          endcase
        end
        if (sh_r != old_r) lastchg = cyc_n;
        s3 = s2; s2 = s1;
        s1 = int'(bus.key_ready);
        vs_prev = int'(bus.vs);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        n_vec++;
        if (bus.x !== 10'(m_x) || bus.y !== 9'(m_y) ||
            bus.radius !== 10'(m_r) ||
            bus.r_sqr !== 20'(m_sq) || bus.upd !== m_upd) begin
          n_err++;
          $display("FAIL cycle %0d: got x=%0d y=%0d r=%0d sq=%0d upd=%0b want x=%0d y=%0d r=%0d sq=%0d upd=%0b",
                   cyc_n, bus.x, bus.y, bus.radius, bus.r_sqr, bus.upd,
                   m_x, m_y, m_r, m_sq, m_upd);
        end
      end
    end
  end

  task automatic chk(string nm, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic lit(string nm, int x, int y, int r, int sq);
    chk({nm, "_x"}, int'(bus.x), x);
    chk({nm, "_y"}, int'(bus.y), y);
    chk({nm, "_r"}, int'(bus.radius), r);
    chk({nm, "_sq"}, int'(bus.r_sqr), sq);
    chk({nm, "_mr"}, m_r, r);
    chk({nm, "_msq"}, m_sq, sq);
  endtask

  task automatic cyc(int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic press(int c, int hold);
    bus.key_code = 5'(c);
    bus.key_ready = 1'b1;
    cyc(hold);
    bus.key_ready = 1'b0;
    cyc(5);
  endtask

  task automatic frame();
    bus.vs = 1'b0;
    cyc(2);
    bus.vs = 1'b1;
    cyc(14);
  endtask

  bit rnd_done = 1'b0;
  int codes[8] = '{'h10, 'h12, 'h0C, 'h0E, 'h09, 'h11, 'h00, 'h1F};

  initial begin
    int d;
    bus.key_ready = 1'b0;
    bus.key_code = 5'd0;
    bus.vs = 1'b1;
    cyc(1);
    chk_en = 1'b1;
    cyc(2);
    rstn = 1'b1;
    lit("reset", 320, 240, 15, 225);
    chk("reset_upd", int'(bus.upd), 0);

    frame();
    lit("first_frame", 320, 240, 15, 225);

    press('h12, 2);
    cyc(3);
    chk("r_before_vs", int'(bus.radius), 15);
    frame();
    lit("r_up", 320, 240, 20, 400);

    repeat (17) press('h0C, 2);
    frame();
    chk("x_floor", int'(bus.x), 0);
    repeat (40) press('h0E, 2);
    frame();
    chk("x_ceil", int'(bus.x), 639);

    repeat (4) press('h10, 2);
    frame();
    lit("r_floor", 639, 240, 5, 25);
    repeat (39) press('h12, 2);
    frame();
    lit("r_ceil", 639, 240, 200, 40000);
    press('h12, 2);
    frame();
    lit("r_ceil_hold", 639, 240, 200, 40000);

    bus.key_code = 5'h11;
    bus.key_ready = 1'b1;
    cyc(RD + 2 * RP + 5);
    bus.key_ready = 1'b0;
    cyc(5);
    frame();
    lit("y_repeat", 639, 320, 200, 40000);

    bus.key_code = 5'h10;
    bus.key_ready = 1'b1;
    cyc(1);
    bus.key_ready = 1'b0;
    cyc(3);
    bus.vs = 1'b0;
    d = 0;
    do begin
      cyc(1);
      d++;
      if (d == 2) bus.vs = 1'b1;
    end while (!bus.upd && d <= 30);
    bus.vs = 1'b1;
    chk("upd_delay", d, 9);
    cyc(15);
    lit("late_commit", 639, 320, 195, 38025);

    bus.key_code = 5'h10;
    bus.key_ready = 1'b1;
    cyc(104);
    bus.vs = 1'b0;
    cyc(1);
    rstn = 1'b0;
    bus.key_ready = 1'b0;
    bus.vs = 1'b1;
    cyc(3);
    rstn = 1'b1;
    cyc(20);
    lit("mid_reset", 320, 240, 15, 225);
    frame();
    lit("post_reset", 320, 240, 15, 225);

    fork
      begin
        for (int i = 0; i < 150; i++) begin
          press(codes[$urandom_range(0, 7)],
                ($urandom_range(0, 9) == 0) ? $urandom_range(100, 150)
                                             : $urandom_range(1, 6));
          cyc($urandom_range(0, 8));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          bus.vs = 1'b0;
          cyc($urandom_range(1, 3));
          bus.vs = 1'b1;
          cyc($urandom_range(3, 40));
        end
      end
    join
    cyc(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
